// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int XLEN    = 32;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Instruction returned for faulted fetches (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One response entry as carried through the delay stages and the queue.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } imem_resp_t;

  // Misaligned PC or word index beyond the populated memory.
  function automatic logic addr_fault(input logic [XLEN-1:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr[XLEN-1:2] >> aw) != '0);
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// In-order response queue: modulo-DEPTH pointers plus a separate occupancy count.
// flush and reset both empty the queue; a push on a flush edge is dropped.
module imem_resp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 65,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // Full + simultaneous pop is a legal push; upstream credits prevent overflow.
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and count bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; not reset, validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: PC request in, instruction word out, in order.
// The memory is read at the acceptance edge (result captured into the first
// delay stage, or straight into the queue when LATENCY is 1). Requests are
// only accepted when a queue slot is guaranteed (credit = in-flight + queued).
// Optional build macro IMEM_PERF_EN adds request/fault/stall counters.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int QDEPTH     = LATENCY + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic [31:0]           io_req_addr,
  output logic                  io_resp_valid,
  input  logic                  io_resp_ready,
  output logic [31:0]           io_resp_inst,
  output logic [31:0]           io_resp_pc,
  output logic                  io_resp_fault,
  input  logic                  io_flush,
  input  logic                  io_wr_en,
  input  logic [ADDR_WIDTH-1:0] io_wr_addr,
  input  logic [31:0]           io_wr_data
`ifdef IMEM_PERF_EN
  ,
  output logic [31:0]           io_perf_reqs,
  output logic [31:0]           io_perf_faults,
  output logic [31:0]           io_perf_stalls
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX || QDEPTH < LATENCY + 1) begin : g_bad_cfg
    $error("imem_responder: illegal LATENCY/QDEPTH combination");
  end

  logic [XLEN-1:0] mem [2**ADDR_WIDTH];
  logic            accept;
  logic            req_fault;
  imem_resp_t      in_ent;
  imem_resp_t      enq_ent;
  imem_resp_t      head;
  logic            enq_vld;
  logic            q_valid;
  logic            pop;
  logic [CW-1:0]   qcount;
  logic [CW-1:0]   inflight;
  logic [CW:0]     occ;

  assign req_fault    = addr_fault(io_req_addr, ADDR_WIDTH);
  assign occ          = {1'b0, inflight} + {1'b0, qcount};
  assign io_req_ready = !reset && !io_flush && (occ < (CW+1)'(QDEPTH));
  assign accept       = io_req_valid & io_req_ready;

  // Entry formed at the acceptance edge; faulted requests never touch memory.
  always_comb begin
    in_ent.pc    = io_req_addr;
    in_ent.fault = req_fault;
    in_ent.inst  = req_fault ? NOP_INST : mem[io_req_addr[ADDR_WIDTH+1:2]];
  end

  // Program-load port; the read above sees the pre-write word (read-first).
  always_ff @(posedge clock) begin
    if (io_wr_en) mem[io_wr_addr] <= io_wr_data;
  end

  if (LATENCY == 1) begin : g_nodly
    assign enq_vld  = accept;
    assign enq_ent  = in_ent;
    assign inflight = '0;
  end else begin : g_dly
    logic [LATENCY-2:0] vld_pipe;
    imem_resp_t         ent_pipe [LATENCY-1];

    // Delay stages; only the valids are cleared by reset/flush.
    always_ff @(posedge clock) begin
      if (reset || io_flush) vld_pipe <= '0;
      else begin
        vld_pipe[0] <= accept;
        for (int i = 1; i < LATENCY-1; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      ent_pipe[0] <= in_ent;
      for (int i = 1; i < LATENCY-1; i++) ent_pipe[i] <= ent_pipe[i-1];
    end

    // Every in-flight stage already holds a reserved queue slot.
    always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY-1; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    assign enq_vld = vld_pipe[LATENCY-2];
    assign enq_ent = ent_pipe[LATENCY-2];
  end

  assign pop = q_valid & io_resp_ready;

  imem_resp_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(imem_resp_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_flush),
    .push      (enq_vld),
    .push_data (enq_ent),
    .pop       (pop),
    .head      (head),
    .valid     (q_valid),
    .count     (qcount)
  );

  // Outputs read as zero whenever nothing is presented.
  assign io_resp_valid = q_valid;
  assign io_resp_inst  = q_valid ? head.inst : '0;
  assign io_resp_pc    = q_valid ? head.pc   : '0;
  assign io_resp_fault = q_valid & head.fault;

`ifdef IMEM_PERF_EN
  // Performance counters; survive flush, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_reqs   <= '0;
      io_perf_faults <= '0;
      io_perf_stalls <= '0;
    end else begin
      if (accept)                       io_perf_reqs   <= io_perf_reqs + 1'b1;
      if (accept && req_fault)          io_perf_faults <= io_perf_faults + 1'b1;
      if (io_req_valid && !io_req_ready) io_perf_stalls <= io_perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 3, 2), one active at a
// time via sel, checked by a scoreboard fed at request acceptance.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [31:0] req_addr [3];
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready = '0;
  logic [31:0] resp_inst [3];
  logic [31:0] resp_pc [3];
  logic [2:0]  resp_fault;
  logic [2:0]  flush = '0;
  logic [2:0]  wr_en = '0;
  logic [9:0]  wr_addr [3];
  logic [31:0] wr_data [3];
`ifdef IMEM_PERF_EN
  logic [31:0] perf_reqs [3];
  logic [31:0] perf_faults [3];
  logic [31:0] perf_stalls [3];
`endif

  int          sel = 0;
  int          checks = 0;
  int          failures = 0;
  int          acc_cnt = 0;
  exp_t        exp_q [$];
  exp_t        e;
  logic        f;
  logic [31:0] model_mem [3][1024];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    imem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT), .QDEPTH(LAT + 1)) u_dut (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (req_valid[g]),
      .io_req_ready  (req_ready[g]),
      .io_req_addr   (req_addr[g]),
      .io_resp_valid (resp_valid[g]),
      .io_resp_ready (resp_ready[g]),
      .io_resp_inst  (resp_inst[g]),
      .io_resp_pc    (resp_pc[g]),
      .io_resp_fault (resp_fault[g]),
      .io_flush      (flush[g]),
      .io_wr_en      (wr_en[g]),
      .io_wr_addr    (wr_addr[g]),
      .io_wr_data    (wr_data[g])
`ifdef IMEM_PERF_EN
      ,
      .io_perf_reqs   (perf_reqs[g]),
      .io_perf_faults (perf_faults[g]),
      .io_perf_stalls (perf_stalls[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Scoreboard: pop/compare on handshake, push on acceptance, then model writes.
  always @(negedge clock) begin
    if (reset) exp_q.delete();
    else begin
      if (resp_valid[sel] && resp_ready[sel]) begin
        if (exp_q.size() == 0) chk("unexpected_resp", {31'b0, resp_valid[sel]}, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_inst", resp_inst[sel], e.inst);
          chk("resp_pc", resp_pc[sel], e.pc);
          chk("resp_fault", {31'b0, resp_fault[sel]}, {31'b0, e.fault});
        end
      end
      if (flush[sel]) begin
        chk("flush_ready", {31'b0, req_ready[sel]}, 0);
        exp_q.delete();
      end else if (req_valid[sel] && req_ready[sel]) begin
        f       = (req_addr[sel][1:0] != 2'b00) || (req_addr[sel][31:12] != '0);
        e.pc    = req_addr[sel];
        e.fault = f;
        e.inst  = f ? NOP : model_mem[sel][req_addr[sel][11:2]];
        exp_q.push_back(e);
        acc_cnt++;
      end
      if (wr_en[sel]) model_mem[sel][wr_addr[sel]] = wr_data[sel];
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    wr_en[sel] = 1'b1; wr_addr[sel] = 10'(idx); wr_data[sel] = d;
    tick();
    wr_en[sel] = 1'b0;
  endtask

  // Holds the request until accepted; leaves req_valid high for back-to-back use.
  task automatic send(input logic [31:0] a, output int waits);
    bit acc;
    req_valid[sel] = 1'b1; req_addr[sel] = a; waits = 0;
    do begin
      @(negedge clock); acc = req_ready[sel];
      tick();
      if (!acc) waits++;
    end while (!acc && waits < 50);
    chk("send_accept", {31'b0, acc}, 1);
  endtask

  task automatic req(input logic [31:0] a);
    int w;
    send(a, w);
  endtask

  task automatic idle();
    req_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) tick();
    chk("drain_idle", {31'b0, resp_valid[sel]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, w;
    logic [31:0] a;
    bit acc;
    for (int g = 0; g < 3; g++) begin req_addr[g] = '0; wr_addr[g] = '0; wr_data[g] = '0; end

    // Reset state of every instance
    repeat (3) tick();
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ready", {31'b0, req_ready[g]}, 0);
      chk("rst_valid", {31'b0, resp_valid[g]}, 0);
      chk("rst_inst", resp_inst[g], 0);
      chk("rst_pc", resp_pc[g], 0);
      chk("rst_fault", {31'b0, resp_fault[g]}, 0);
    end
    tick();
    reset = 1'b0;
    tick();

    // LATENCY=1 basic back-to-back reads
    sel = 0; resp_ready[0] = 1'b1;
    wr(0, 32'h1111_1111); wr(1, 32'h2222_2222); wr(1023, 32'hA5A5_5A5A);
    chk("idle_ready", {31'b0, req_ready[0]}, 1);
    req(32'h0);
    chk("lat1_valid", {31'b0, resp_valid[0]}, 1);
    req(32'h4);
    idle();
    drain();

    // Faults plus the last in-range word
    req(32'h6); req(32'h0000_1000); req(32'h0000_0FFC); req(32'h8000_0000);
    idle();
    drain();

    // LATENCY=3: credits stop acceptance at 4 with the consumer stalled
    sel = 1; resp_ready[1] = 1'b0;
    for (int i = 0; i < 8; i++) wr(i, 32'hC0DE_0000 + 32'(i));
    base = acc_cnt; a = 0; req_valid[1] = 1'b1; req_addr[1] = a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); acc = req_ready[1];
      tick();
      if (acc) begin a += 4; req_addr[1] = a; end
    end
    idle();
    chk("credit_accepts", 32'(acc_cnt - base), 4);
    chk("credit_ready", {31'b0, req_ready[1]}, 0);
    chk("stall_head_pc", resp_pc[1], 0);
    resp_ready[1] = 1'b1;
    tick();
    chk("ready_after_deq", {31'b0, req_ready[1]}, 1);
    drain();

    // LATENCY=3 full throughput
    for (int i = 0; i < 6; i++) begin
      send(32'(i * 4), w);
      chk("tput_waits", 32'(w), 0);
    end
    idle();
    drain();

    // LATENCY=2 flush discards everything in flight
    sel = 2; resp_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, 32'hBEEF_0000 + 32'(i));
    req(32'h0); req(32'h4); req(32'h8);
    req_addr[2] = 32'hC;
    flush[2] = 1'b1;
    tick();
    flush[2] = 1'b0; idle();
    chk("flush_valid0", {31'b0, resp_valid[2]}, 0);
    tick();
    chk("flush_valid1", {31'b0, resp_valid[2]}, 0);
    resp_ready[2] = 1'b1;
    req(32'hC);
    idle();
    chk("lat2_early", {31'b0, resp_valid[2]}, 0);
    tick();
    chk("lat2_valid", {31'b0, resp_valid[2]}, 1);
    drain();

    // Read-first on a same-edge write
    sel = 0;
    wr(5, 32'h5555_5555);
    wr_en[0] = 1'b1; wr_addr[0] = 10'd5; wr_data[0] = 32'hDEAD_BEEF;
    req(32'h14);
    wr_en[0] = 1'b0;
    req(32'h14);
    idle();
    drain();

`ifdef IMEM_PERF_EN
    // Counters: 10 accepted (2 faulted) and 3 stall cycles held by flush
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    chk("perf_rst_reqs", perf_reqs[0], 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) req(32'h2 + 32'(i * 4));
      else req((i % 2 == 0) ? 32'h0 : 32'h4);
    end
    idle();
    drain();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; flush[0] = 1'b1;
    repeat (3) tick();
    flush[0] = 1'b0; idle();
    tick();
    chk("perf_reqs", perf_reqs[0], 10);
    chk("perf_faults", perf_faults[0], 2);
    chk("perf_stalls", perf_stalls[0], 3);
    reset = 1'b1; repeat (2) tick();
    chk("perf_clr_reqs", perf_reqs[0], 0);
    chk("perf_clr_faults", perf_faults[0], 0);
    chk("perf_clr_stalls", perf_stalls[0], 0);
    reset = 1'b0; tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
